// File: rtl/mem_access_unit.sv
// Initiator for the word-wide data-memory port: byte/half/word loads and stores,
// with read-modify-write for sub-word stores. Optional write trace: MAU_TRACE_EN.
module mem_access_unit #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned ALIGN_CHECK = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [31:0]       req_pc,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [31:0]       mem_pc,
   input  logic [31:0]       mem_rdata,
   output logic [1:0]        dbg_state_o
);

   // Handshake: a request transfers on a cycle where req_valid && req_ready;
   // req_ready is high only in IDLE, and nothing offered while busy is kept.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WR   = 2'd2,
      S_RESP = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              err_q;
   logic [31:0]       wdata_q;
   logic [31:0]       pc_q;
   logic [31:0]       rdata_q;

   logic              accept;
   logic              req_err;
   logic [7:0]        byte_lane;
   logic [15:0]       half_lane;
   logic [31:0]       load_ext;
   logic [31:0]       merged;

   always_comb begin
      req_err = 1'b0;
      if (req_size == 2'd3) begin
         req_err = 1'b1;
      end else if (ALIGN_CHECK != 0) begin
         if ((req_size == 2'd1) && req_addr[0]) req_err = 1'b1;
         if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) req_err = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      mem_we    = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               // Sub-word stores read the old word first to merge into it.
               if (req_err)                state_d = S_RESP;
               else if (!req_we)           state_d = S_RD;
               else if (req_size == 2'd2)  state_d = S_WR;
               else                        state_d = S_RD;
            end
         end
         S_RD:   state_d = we_q ? S_WR : S_RESP;
         S_WR: begin
            mem_we  = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            rsp_valid = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         size_q  <= 2'd0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         wdata_q <= '0;
         pc_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            err_q   <= req_err;
            wdata_q <= req_wdata;
            pc_q    <= req_pc;
         end
         if (state_q == S_RD) rdata_q <= mem_rdata;
      end
   end

   // Little-endian lanes: byte lane addr[1:0], half lane addr[1].
   assign byte_lane = rdata_q[{addr_q[1:0], 3'b000} +: 8];
   assign half_lane = rdata_q[{addr_q[1], 4'b0000} +: 16];

   always_comb begin
      unique case (size_q)
         2'd0:    load_ext = uns_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
         2'd1:    load_ext = uns_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
         default: load_ext = rdata_q;
      endcase
   end

   always_comb begin
      merged = rdata_q;
      unique case (size_q)
         2'd0:    merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
         2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
         default: merged = wdata_q;
      endcase
   end

   assign rsp_rdata   = ((state_q == S_RESP) && !we_q && !err_q) ? load_ext : 32'h0;
   assign rsp_err     = (state_q == S_RESP) && err_q;
   assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
   assign mem_wdata   = (state_q == S_WR) ? merged : 32'h0;
   assign mem_pc      = pc_q;
   assign dbg_state_o = state_q;

`ifdef MAU_TRACE_EN
   always @(posedge clk) begin
      if (state_q == S_WR) $display("@%08h: *%08h <= %08h", mem_pc, mem_addr, mem_wdata);
   end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: word-level memory and response model, per-cycle
// compare process, directed request list with hand-computed pins.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_pc;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  mem_access_unit #(.ADDR_W(32), .ALIGN_CHECK(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_pc(req_pc),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_pc(mem_pc), .mem_rdata(mem_rdata), .dbg_state_o(dbg_state)
  );

  // clock / reset / memory environment
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] dmem [0:63] = '{default: 32'h0};
  always @(posedge clk) if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
  assign mem_rdata = dmem[mem_addr[7:2]];

  // model state and scoreboard queues
  logic [31:0] ref_mem [0:63] = '{default: 32'h0};
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          chk_en = 1'b0;
  int          busy_from = 1;
  int          busy_to = 0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  int          rsp_cyc_q[$];
  logic [31:0] exp_rdata_q[$];
  logic [31:0] exp_err_q[$];
  int          wr_cyc_q[$];
  logic [31:0] exp_waddr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [31:0] exp_wpc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h (cycle %0d, state %0d)", name, act, exp, cyc, dbg_state);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                             input logic uns, input logic [1:0] ofs);
    logic [31:0] v;
    if (size == 2'd0) begin
      v = (w >> (8 * ofs)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (w >> (16 * ofs[1])) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [1:0] size,
                                              input logic [31:0] wd, input logic [1:0] ofs);
    logic [31:0] m;
    if (size == 2'd0) begin
      m = 32'hFF << (8 * ofs);
      return (w & ~m) | ((wd & 32'hFF) << (8 * ofs));
    end else if (size == 2'd1) begin
      m = 32'hFFFF << (16 * ofs[1]);
      return (w & ~m) | ((wd & 32'hFFFF) << (16 * ofs[1]));
    end
    return wd;
  endfunction

  // compare process: every cycle after reset
  logic exp_rv, exp_we;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(!((cyc >= busy_from) && (cyc <= busy_to))));
      exp_rv = (rsp_cyc_q.size() != 0) && (rsp_cyc_q[0] == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata_q[0]);
        chk("rsp_err", 32'(rsp_err), exp_err_q[0]);
        void'(rsp_cyc_q.pop_front());
        void'(exp_rdata_q.pop_front());
        void'(exp_err_q.pop_front());
      end
      exp_we = (wr_cyc_q.size() != 0) && (wr_cyc_q[0] == cyc);
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
        chk("mem_addr", mem_addr, exp_waddr_q[0]);
        chk("mem_wdata", mem_wdata, exp_wdata_q[0]);
        chk("mem_pc", mem_pc, exp_wpc_q[0]);
        void'(wr_cyc_q.pop_front());
        void'(exp_waddr_q.pop_front());
        void'(exp_wdata_q.pop_front());
        void'(exp_wpc_q.pop_front());
      end
    end
  end

  // driver: one request; lit pins the model (write word for good stores, rdata otherwise)
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] lit, input logic hold);
    int          acc, lat;
    logic        err;
    logic [31:0] w, res, newv;
    @(negedge clk);
    acc    = cyc;
    pc_ctr = pc_ctr + 32'd4;
    w      = ref_mem[addr[7:2]];
    err    = (size == 2'd3) || ((size == 2'd1) && addr[0]) || ((size == 2'd2) && (addr[1:0] != 2'b00));
    res    = 32'h0;
    newv   = 32'h0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      lat = 2;
      res = model_load(w, size, uns, addr[1:0]);
    end else begin
      lat  = (size == 2'd2) ? 2 : 3;
      newv = model_store(w, size, wdata, addr[1:0]);
      ref_mem[addr[7:2]] = newv;
      wr_cyc_q.push_back(acc + lat - 1);
      exp_waddr_q.push_back({addr[31:2], 2'b00});
      exp_wdata_q.push_back(newv);
      exp_wpc_q.push_back(pc_ctr);
    end
    if (!err && we) chk("model_wr", newv, lit);
    else            chk("model_rd", res, lit);
    rsp_cyc_q.push_back(acc + lat);
    exp_rdata_q.push_back(res);
    exp_err_q.push_back(32'(err));
    busy_from    = acc + 1;
    busy_to      = acc + lat;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_pc       = pc_ctr;
    repeat (lat) begin
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
    end
    req_valid = 1'b0;
  endtask

  // sub-word store aborted by reset during its read cycle
  task automatic do_abort_sb(input logic [31:0] addr, input logic [31:0] wdata);
    int acc;
    @(negedge clk);
    acc          = cyc;
    busy_from    = acc + 1;
    busy_to      = acc + 1;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = addr;
    req_wdata    = wdata;
    req_pc       = 32'hBAD0_0000;
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_pc", mem_pc, 32'h0);
    reset  = 1'b0;
    chk_en = 1'b1;

    //     we    size  uns   addr         wdata         lit           hold
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h55,       32'hDEAD55EF, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h11, 32'h0,        32'h00000055, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000DE, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h12, 32'h8001,     32'h8001BEEF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF8001, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h00008001, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'hFFFFFFEF, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 1'b0);
    do_req(1'b0, 2'd1, 1'b1, 32'h10, 32'h0,        32'h0000BEEF, 1'b0);
    // error cases: misaligned word/half, illegal size on load and store
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b0);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b0);
    do_req(1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 32'h0,        1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h13, 32'hFFFF,     32'h0,        1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'h11, 32'hFFFFFFFF, 32'h0,        1'b0);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h7F,       32'h7F01BEEF, 1'b0);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h7F01BEEF, 1'b0);
    do_req(1'b1, 2'd1, 1'b0, 32'h16, 32'hCAFE,     32'hCAFE0000, 1'b0);
    do_req(1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        32'hFFFFCAFE, 1'b0);
    do_req(1'b0, 2'd0, 1'b0, 32'h17, 32'h0,        32'hFFFFFFCA, 1'b0);
    do_req(1'b0, 2'd0, 1'b1, 32'h16, 32'h0,        32'h000000FE, 1'b0);
    // request held valid across the whole busy period
    do_req(1'b1, 2'd0, 1'b0, 32'h20, 32'hA5,       32'h000000A5, 1'b1);
    do_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0,        32'hFFFFFFA5, 1'b0);
    do_req(1'b1, 2'd2, 1'b0, 32'h24, 32'h01234567, 32'h01234567, 1'b1);
    do_req(1'b0, 2'd2, 1'b0, 32'h24, 32'h0,        32'h01234567, 1'b1);
    // reset during the read half of a byte store
    do_abort_sb(32'h10, 32'h00);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h7F01BEEF, 1'b0);

    repeat (4) @(negedge clk);
    chk("rsp_left", 32'(rsp_cyc_q.size()), 32'h0);
    chk("wr_left", 32'(wr_cyc_q.size()), 32'h0);
    for (int i = 0; i < 64; i++) chk($sformatf("mem[%0d]", i), dmem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
